// File: rtl/fp_exec_unit_if.sv
// ============================================================================
// fp_exec_unit_if : request/response bundle for the multicycle FP execute unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface fp_exec_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;
    logic        done;

    modport master (output start, op, a, b, input result, flags, busy, done);
    modport slave  (input start, op, a, b, output result, flags, busy, done);
endinterface

`default_nettype wire

// File: rtl/fp_exec_unit.sv
// ============================================================================
// fp_exec_unit : 4-cycle single-precision add/sub/mul, flush-to-zero, truncate
// Revision 1.0
// ============================================================================
`default_nettype none

module fp_exec_unit #(
    parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
    input  logic          clk,
    input  logic          reset,
    fp_exec_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        EXEC   = 3'd2,
        NORM   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = UNPACK;
            UNPACK:  next_state = EXEC;
            EXEC:    next_state = NORM;
            NORM:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.busy = (state == UNPACK) || (state == EXEC) || (state == NORM);
    assign bus.done = (state == DONE);

    logic [31:0] a_lat, b_lat;
    logic [1:0]  op_lat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_lat  <= 32'd0;
            b_lat  <= 32'd0;
            op_lat <= 2'd0;
        end else if (state == IDLE && bus.start) begin
            a_lat  <= bus.a;
            b_lat  <= bus.b;
            op_lat <= bus.op;
        end
    end

    // ---------------- UNPACK ----------------
    logic        sa, sb, za, zb, special, is_mul;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa <= 1'b0; sb <= 1'b0; za <= 1'b0; zb <= 1'b0;
            special <= 1'b0; is_mul <= 1'b0;
            ea <= 8'd0; eb <= 8'd0; ma <= 24'd0; mb <= 24'd0;
        end else if (state == UNPACK) begin
            sa      <= a_lat[31];
            sb      <= b_lat[31] ^ (op_lat == 2'b01);
            za      <= (a_lat[30:23] == 8'd0);
            zb      <= (b_lat[30:23] == 8'd0);
            special <= (op_lat == 2'b11) || (a_lat[30:23] == 8'hFF) || (b_lat[30:23] == 8'hFF);
            is_mul  <= (op_lat == 2'b10);
            ea      <= a_lat[30:23];
            eb      <= b_lat[30:23];
            ma      <= (a_lat[30:23] == 8'd0) ? 24'd0 : {1'b1, a_lat[22:0]};
            mb      <= (b_lat[30:23] == 8'd0) ? 24'd0 : {1'b1, b_lat[22:0]};
        end
    end

    // ---------------- EXEC ----------------
    // Larger magnitude goes first so the effective subtraction never goes negative.
    logic        swap, big_s, sml_s, cancel;
    logic [7:0]  big_e, sml_e, diff;
    logic [23:0] big_m, sml_m;
    logic [26:0] big_x, sml_x;
    logic [27:0] sum;
    logic [47:0] prod;

    always_comb begin
        swap   = (eb > ea) || ((eb == ea) && (mb > ma));
        big_s  = swap ? sb : sa;
        sml_s  = swap ? sa : sb;
        big_e  = swap ? eb : ea;
        sml_e  = swap ? ea : eb;
        big_m  = swap ? mb : ma;
        sml_m  = swap ? ma : mb;
        diff   = big_e - sml_e;
        big_x  = {big_m, 3'b000};
        sml_x  = (diff >= 8'd27) ? 27'd0 : ({sml_m, 3'b000} >> diff);
        sum    = (big_s == sml_s) ? ({1'b0, big_x} + {1'b0, sml_x})
                                  : ({1'b0, big_x} - {1'b0, sml_x});
        cancel = (sa != sb) && (ea == eb) && (ma == mb);
        prod   = {24'd0, ma} * {24'd0, mb};
    end

    logic               bypass, bypass_v, res_sign;
    logic [31:0]        bypass_val;
    logic [47:0]        man;
    logic signed [9:0]  exp_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bypass <= 1'b0; bypass_v <= 1'b0; bypass_val <= 32'd0;
            res_sign <= 1'b0; man <= 48'd0; exp_base <= 10'sd0;
        end else if (state == EXEC) begin
            bypass   <= 1'b0;
            bypass_v <= 1'b0;
            bypass_val <= 32'd0;
            if (is_mul) begin
                res_sign <= sa ^ sb;
                man      <= prod;
                exp_base <= $signed({2'b00, ea} + {2'b00, eb} - 10'd127);
            end else begin
                res_sign <= big_s;
                man      <= {sum, 20'd0};
                exp_base <= $signed({2'b00, big_e});
            end
            if (special) begin
                bypass     <= 1'b1;
                bypass_v   <= 1'b1;
                bypass_val <= NAN_VALUE;
            end else if (is_mul) begin
                if (za || zb) begin
                    bypass     <= 1'b1;
                    bypass_val <= {sa ^ sb, 31'd0};
                end
            end else if (cancel) begin
                bypass     <= 1'b1;
                bypass_val <= 32'd0;
            end else if (za) begin
                bypass     <= 1'b1;
                bypass_val <= zb ? {sb, 31'd0} : {sb, eb, mb[22:0]};
            end else if (zb) begin
                bypass     <= 1'b1;
                bypass_val <= {sa, ea, ma[22:0]};
            end
        end
    end

    // ---------------- NORM ----------------
    logic [5:0]        lead;
    logic [47:0]       shifted;
    logic signed [9:0] norm_exp;
    logic [31:0]       next_result;
    logic              next_v;
    logic              unused_bits;

    always_comb begin
        lead = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (man[i]) lead = i[5:0];
        end
        shifted  = man << (6'd47 - lead);
        norm_exp = exp_base + $signed({4'd0, lead}) - 10'sd46;
        next_v   = 1'b0;
        if (bypass) begin
            next_result = bypass_val;
            next_v      = bypass_v;
        end else if (norm_exp >= 10'sd255) begin
            next_result = {res_sign, 8'hFF, 23'd0};
            next_v      = 1'b1;
        end else if (norm_exp <= 10'sd0) begin
            next_result = {res_sign, 31'd0};
        end else begin
            next_result = {res_sign, norm_exp[7:0], shifted[46:24]};
        end
    end

    assign unused_bits = ^{shifted[47], shifted[23:0], norm_exp[9:8]};

    logic [31:0] result_reg;
    logic [3:0]  flags_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg <= 32'd0;
            flags_reg  <= 4'd0;
        end else if (state == NORM) begin
            result_reg <= next_result;
            flags_reg  <= {next_result[31], (next_result[30:0] == 31'd0), 1'b0, next_v};
        end
    end

    assign bus.result = result_reg;
    assign bus.flags  = flags_reg;

endmodule

`default_nettype wire

// File: tb/tb_fp_exec_unit.sv
// ============================================================================
// tb_fp_exec_unit : directed + randomized checks against an arithmetic model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fp_exec_unit;

    localparam logic [31:0] NANV = 32'h7FC00000;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    fp_exec_unit_if bus ();

    fp_exec_unit #(.NAN_VALUE(NANV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Packs a normalized value whose mantissa carries the hidden bit at bit 23.
    function automatic logic [32:0] pack(input bit sign, input int e, input longint m24);
        if (e >= 255)     return {1'b1, sign, 8'hFF, 23'd0};
        else if (e <= 0)  return {1'b0, sign, 31'd0};
        else              return {1'b0, sign, e[7:0], m24[22:0]};
    endfunction

    function automatic logic [35:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, diff;
        bit sa, sb, v;
        longint ma, mb, p, s, big, sml;
        logic [32:0] pk;
        logic [31:0] r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = a[31];
        sb = b[31] ^ (op == 2'b01);
        ma = (ea == 0) ? 64'd0 : (longint'(a[22:0]) + 64'h800000);
        mb = (eb == 0) ? 64'd0 : (longint'(b[22:0]) + 64'h800000);
        v  = 1'b0;
        if (op == 2'b11 || ea == 255 || eb == 255) return {NANV, 4'b0001};
        if (op == 2'b10) begin
            if (ea == 0 || eb == 0) r = {sa ^ sb, 31'd0};
            else begin
                p = ma * mb;
                e = ea + eb - 127;
                if (p >= (64'd1 << 47)) begin e++; p = p >> 24; end
                else p = p >> 23;
                pk = pack(sa ^ sb, e, p);
                v = pk[32]; r = pk[31:0];
            end
        end else begin
            if (ea == 0 && eb == 0) r = (sa == sb) ? {sa, 31'd0} : 32'd0;
            else if (ea == 0)       r = {sb, b[30:0]};
            else if (eb == 0)       r = {sa, a[30:0]};
            else begin
                if (ea >= eb) begin
                    e = ea; diff = ea - eb;
                    big = sa ? -ma * 8 : ma * 8;
                    sml = (diff >= 27) ? 0 : ((mb * 8) >> diff);
                    if (sb) sml = -sml;
                end else begin
                    e = eb; diff = eb - ea;
                    big = sb ? -mb * 8 : mb * 8;
                    sml = (diff >= 27) ? 0 : ((ma * 8) >> diff);
                    if (sa) sml = -sml;
                end
                s = big + sml;
                if (s == 0) r = 32'd0;
                else begin
                    bit neg;
                    neg = (s < 0);
                    if (neg) s = -s;
                    while (s >= (64'd1 << 27)) begin s = s >> 1; e++; end
                    while (s <  (64'd1 << 26)) begin s = s << 1; e--; end
                    pk = pack(neg, e, s >> 3);
                    v = pk[32]; r = pk[31:0];
                end
            end
        end
        return {r, r[31], (r[30:0] == 31'd0), 1'b0, v};
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output logic [3:0] flg);
        int lat;
        logic [35:0] exp_v;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        exp_v = ref_model(op, a, b);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_result"}, 64'(bus.result), 64'(exp_v[35:4]));
        check({tag, "_flags"}, 64'(bus.flags), 64'(exp_v[3:0]));
        res = bus.result;
        flg = bus.flags;
    endtask

    logic [31:0] res, ra, rb;
    logic [3:0]  flg, busy_seen, done_seen;
    logic [1:0]  rop;
    int          done_cnt;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = 32'd0; bus.b = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_flags", 64'(bus.flags), 64'd0);
        check("reset_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        reset = 1'b0;

        do_op("add_1p2", 2'b00, 32'h3F800000, 32'h40000000, res, flg);
        check("add_1p2_const", 64'({res, flg}), {28'd0, 32'h40400000, 4'b0000});
        do_op("sub_cancel", 2'b01, 32'h3FC00000, 32'h3FC00000, res, flg);
        check("sub_cancel_const", 64'({res, flg}), {28'd0, 32'h00000000, 4'b0100});
        do_op("mul_3xm2", 2'b10, 32'h40400000, 32'hC0000000, res, flg);
        check("mul_3xm2_const", 64'({res, flg}), {28'd0, 32'hC0C00000, 4'b1000});
        do_op("mul_ovf", 2'b10, 32'h7F000000, 32'h7F000000, res, flg);
        check("mul_ovf_const", 64'({res, flg}), {28'd0, 32'h7F800000, 4'b0001});
        do_op("op_rsvd", 2'b11, 32'h3F800000, 32'h3F800000, res, flg);
        check("op_rsvd_const", 64'({res, flg}), {28'd0, 32'h7FC00000, 4'b0001});
        do_op("inf_in", 2'b00, 32'h7F800000, 32'h3F800000, res, flg);
        check("inf_in_const", 64'({res, flg}), {28'd0, 32'h7FC00000, 4'b0001});
        do_op("denorm_add", 2'b00, 32'h00000001, 32'h3F800000, res, flg);
        check("denorm_add_const", 64'({res, flg}), {28'd0, 32'h3F800000, 4'b0000});
        do_op("zero_sub", 2'b01, 32'h00000000, 32'h40000000, res, flg);
        check("zero_sub_const", 64'({res, flg}), {28'd0, 32'hC0000000, 4'b1000});
        do_op("mul_zero", 2'b10, 32'h80000000, 32'h40000000, res, flg);
        check("mul_zero_const", 64'({res, flg}), {28'd0, 32'h80000000, 4'b1100});
        do_op("mul_unf", 2'b10, 32'h00800000, 32'h00800000, res, flg);
        check("mul_unf_const", 64'({res, flg}), {28'd0, 32'h00000000, 4'b0100});

        // start held high while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'h40400000; bus.b = 32'hC0000000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.a = $urandom; bus.b = $urandom;
            busy_seen[3-k] = bus.busy;
            done_seen[3-k] = bus.done;
            if (k == 3) bus.start = 1'b0;
        end
        check("busy_pattern", 64'(busy_seen), 64'b1110);
        check("done_pattern", 64'(done_seen), 64'b0001);
        check("ignored_start_result", 64'({bus.result, bus.flags}), {28'd0, 32'hC0C00000, 4'b1000});
        @(negedge clk);
        check("held_result", 64'({bus.result, bus.busy, bus.done}), {30'd0, 32'hC0C00000, 2'b00});

        // reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h3F800000; bus.b = 32'h40000000;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midreset_outputs", 64'({bus.result, bus.flags, bus.busy, bus.done}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("no_done_after_abort", 64'(done_cnt), 64'd0);
        do_op("after_reset", 2'b00, 32'h3F800000, 32'h40000000, res, flg);

        for (int n = 0; n < 300; n++) begin
            rop = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                int e;
                e = int'(ra[30:23]) + $urandom_range(0, 6) - 3;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                rb[30:23] = e[7:0];
            end
            if ($urandom_range(0, 15) == 0) rb[30:23] = 8'd0;
            if ($urandom_range(0, 31) == 0) rb = ra ^ 32'h80000000;
            if ($urandom_range(0, 31) == 0) begin rb = ra; rop = 2'b01; end
            do_op("rand", rop, ra, rb, res, flg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
